// File: rtl/data_axi_bridge.sv
// Bridges the core's single-cycle data SRAM port onto AXI4 with one access in flight.
// The core is stalled from request acceptance until the access reaches the DONE state.
module data_axi_bridge #(
  parameter logic [3:0] RdId = 4'd1,
  parameter logic [3:0] WrId = 4'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // core data SRAM port
  input  logic        data_sram_en_i,
  input  logic [3:0]  data_sram_wen_i,
  input  logic [31:0] data_sram_addr_i,
  input  logic [31:0] data_sram_wdata_i,
  output logic [31:0] data_sram_rdata_o,
  output logic        stall_req_o,
  output logic        bus_err_o,
  // AXI read address
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // AXI read data
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  // AXI write address
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  // AXI write data
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  // AXI write response
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wen_q, wen_d;
  logic [1:0]  resp_q, resp_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs, w_hs;

  // Single outstanding transaction makes the returned IDs unambiguous.
  logic unused_ids;
  assign unused_ids = ^{rid_i, bid_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wen_q     <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wen_q     <= wen_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wen_d       = wen_q;
    resp_d      = resp_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    stall_req_o = 1'b1;
    bus_err_o   = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with reset so the core is never stalled while the bridge is held in reset.
        stall_req_o = data_sram_en_i & rst_ni;
        if (data_sram_en_i) begin
          addr_d    = data_sram_addr_i;
          wdata_d   = data_sram_wdata_i;
          wen_d     = data_sram_wen_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (data_sram_wen_i == 4'b0000) ? StRdAddr : StWrReq;
        end
      end
      StRdAddr: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = StRdData;
      end
      StRdData: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) begin
          rdata_d = rdata_i;
          resp_d  = rresp_i;
          state_d = StDone;
        end
      end
      StWrReq: begin
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        aw_hs     = awvalid_o & awready_i;
        w_hs      = wvalid_o & wready_i;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          resp_d  = bresp_i;
          state_d = StDone;
        end
      end
      StDone: begin
        stall_req_o = 1'b0;
        bus_err_o   = (resp_q != 2'b00);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_sram_rdata_o = rdata_q;

  assign arid_o    = RdId;
  assign araddr_o  = {addr_q[31:2], 2'b00};
  assign arlen_o   = 8'd0;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;

  assign awid_o    = WrId;
  assign awaddr_o  = {addr_q[31:2], 2'b00};
  assign awlen_o   = 8'd0;
  assign awsize_o  = 3'b010;
  assign awburst_o = 2'b01;

  assign wdata_o   = wdata_q;
  assign wstrb_o   = wen_q;
  assign wlast_o   = 1'b1;

endmodule
